cdb_arbiter: RTL and testbench

Arbitrates the multi-cycle functional units (mult, ALU, load) onto the single Common Data Bus, and is the direct consumer of each FU's done/value/tag output. Each cycle it selects one FU holding `done` by round-robin and returns a same-cycle `ack` to that FU. It registers the winner's result onto the CDB for one cycle, where the RS, ROB and map table snoop it. It also keeps broadcast and conflict counters for performance debug.

---
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter that places one functional-unit result per cycle onto the
// Common Data Bus. The winner is acked combinationally in the same cycle and
// its result is broadcast from a register on the following cycle.
//
// Handshake (done/ack): an FU raises fu_done[i] with fu_value[i]/fu_rob_tag[i]
// stable and holds all three until it samples fu_ack[i]=1 on a rising edge.
// The transfer happens on exactly that edge. fu_ack is one-hot, only ever set
// for a lane whose done is high, and is all-zero during flush or reset.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   flush          in   synchronous squash; blocks grants for that cycle
//   fu_done        in   [NUM_FU]          per-FU result ready
//   fu_value       in   [NUM_FU][XLEN]    per-FU result value
//   fu_rob_tag     in   [NUM_FU][TAG_W]   per-FU destination ROB tag
//   fu_ack         out  [NUM_FU]          one-hot grant (combinational)
//   cdb_valid      out                    registered broadcast valid
//   cdb_value      out  [XLEN]            registered broadcast value
//   cdb_rob_tag    out  [TAG_W]           registered broadcast tag
//   cdb_fu_id      out  [ID_W]            registered winning FU index
//   bcast_count    out  [32]              total broadcasts (wraps)
//   conflict_count out  [32]              grants made while >=2 FUs were ready
//   rr_ptr         out  [ID_W]            round-robin pointer, debug visibility
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int NUM_FU = 4,
  parameter  int XLEN   = 32,
  parameter  int TAG_W  = 5,
  localparam int ID_W   = $clog2(NUM_FU)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_FU-1:0]                 fu_done,
  input  logic [NUM_FU-1:0][XLEN-1:0]       fu_value,
  input  logic [NUM_FU-1:0][TAG_W-1:0]      fu_rob_tag,
  output logic [NUM_FU-1:0]                 fu_ack,
  output logic                              cdb_valid,
  output logic [XLEN-1:0]                   cdb_value,
  output logic [TAG_W-1:0]                  cdb_rob_tag,
  output logic [ID_W-1:0]                   cdb_fu_id,
  output logic [31:0]                       bcast_count,
  output logic [31:0]                       conflict_count,
  output logic [ID_W-1:0]                   rr_ptr
);

  logic [ID_W-1:0]   ptr;

  logic              hi_found;
  logic [ID_W-1:0]   hi_idx;
  logic              lo_found;
  logic [ID_W-1:0]   lo_idx;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   next_ptr;
  logic              any_done;
  logic              multi_done;
  logic              grant;

  // The wrapping search from ptr is split into two ascending scans:
  // the first ready lane at or above ptr wins; if there is none, the lowest
  // ready lane overall wins (that is the wrap-around part of the search).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_done[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (fu_done[i] && !hi_found && (i >= int'(ptr))) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
  end

  assign win_idx  = hi_found ? hi_idx : lo_idx;
  assign any_done = |fu_done;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_done = |(fu_done & (fu_done - NUM_FU'(1)));

  // reset is folded in so the ack is forced low the instant reset asserts,
  // not just after the registers clear.
  assign grant = any_done && !flush && reset;

  always_comb begin
    fu_ack = '0;
    if (grant) begin
      fu_ack[win_idx] = 1'b1;
    end
  end

  // Explicit wrap keeps this correct for NUM_FU that is not a power of two.
  assign next_ptr = (win_idx == ID_W'(NUM_FU - 1)) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      cdb_valid      <= 1'b0;
      cdb_value      <= '0;
      cdb_rob_tag    <= '0;
      cdb_fu_id      <= '0;
      bcast_count    <= '0;
      conflict_count <= '0;
    end else if (grant) begin
      ptr            <= next_ptr;
      cdb_valid      <= 1'b1;
      cdb_value      <= fu_value[win_idx];
      cdb_rob_tag    <= fu_rob_tag[win_idx];
      cdb_fu_id      <= win_idx;
      bcast_count    <= bcast_count + 32'd1;
      if (multi_done) begin
        conflict_count <= conflict_count + 32'd1;
      end
    end else begin
      // No grant (idle or flush): drop valid, hold payload, pointer, counters.
      cdb_valid <= 1'b0;
    end
  end

  assign rr_ptr = ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter with NUM_FU=4. A reference model tracks the
// round-robin pointer and counters; each cycle it predicts the ack, and for
// every grant pushes the expected broadcast into exp_q, which is popped and
// compared when the registered CDB output appears one edge later. The FUs are
// modelled in the bench: a lane drops done on the edge it is acked.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int TW = 5;
  localparam int IW = 2;
  localparam int QW = IW + TW + XL;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush = 1'b0;
  logic [N-1:0]            fu_done = '0;
  logic [N-1:0][XL-1:0]    fu_value = '0;
  logic [N-1:0][TW-1:0]    fu_rob_tag = '0;
  logic [N-1:0]            fu_ack;
  logic                    cdb_valid;
  logic [XL-1:0]           cdb_value;
  logic [TW-1:0]           cdb_rob_tag;
  logic [IW-1:0]           cdb_fu_id;
  logic [31:0]             bcast_count;
  logic [31:0]             conflict_count;
  logic [IW-1:0]           rr_ptr;

  cdb_arbiter #(.NUM_FU(N), .XLEN(XL), .TAG_W(TW)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fu_done        (fu_done),
    .fu_value       (fu_value),
    .fu_rob_tag     (fu_rob_tag),
    .fu_ack         (fu_ack),
    .cdb_valid      (cdb_valid),
    .cdb_value      (cdb_value),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_fu_id      (cdb_fu_id),
    .bcast_count    (bcast_count),
    .conflict_count (conflict_count),
    .rr_ptr         (rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  logic [QW-1:0]  exp_q[$];
  logic [IW-1:0]  m_ptr;
  logic [31:0]    m_bcast;
  logic [31:0]    m_conf;
  int             age[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr   = '0;
    m_bcast = '0;
    m_conf  = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) age[i] = 0;
  endtask

  // Called just after a rising edge (inputs already driven). Checks the
  // combinational ack mid-cycle, crosses the next edge, applies the FU model,
  // then checks the registered outputs against the scoreboard.
  task automatic tick();
    logic [N-1:0]  exp_ack;
    logic [QW-1:0] e;
    int            win;
    int            pc;
    int            idx;
    #1;
    exp_ack = '0;
    win     = -1;
    pc      = 0;
    for (int i = 0; i < N; i++) if (fu_done[i]) pc++;
    if (!flush) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(m_ptr) + k) % N;
        if (win < 0 && fu_done[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ack[win] = 1'b1;
    check("fu_ack", 64'(fu_ack), 64'(exp_ack));
    if (win >= 0) begin
      exp_q.push_back({IW'(win), fu_rob_tag[win], fu_value[win]});
      check("fairness_age", 64'(age[win] < N), 64'(1));
      m_ptr   = IW'((win + 1) % N);
      m_bcast = m_bcast + 32'd1;
      if (pc >= 2) m_conf = m_conf + 32'd1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == win) age[i] = 0;
      else if (fu_done[i] && !flush) age[i] = age[i] + 1;
    end
    @(posedge clock);
    #1;
    fu_done = fu_done & ~exp_ack;
    check("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cdb_value", 64'(cdb_value), 64'(e[XL-1:0]));
      check("cdb_rob_tag", 64'(cdb_rob_tag), 64'(e[XL+TW-1:XL]));
      check("cdb_fu_id", 64'(cdb_fu_id), 64'(e[QW-1:XL+TW]));
    end
    check("bcast_count", 64'(bcast_count), 64'(m_bcast));
    check("conflict_count", 64'(conflict_count), 64'(m_conf));
    check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
  endtask

  // Asserts reset between edges, checks everything clears before the next
  // edge and that ack stays low while held, then releases after one edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_value", 64'(cdb_value), 64'(0));
    check("rst_tag", 64'(cdb_rob_tag), 64'(0));
    check("rst_fu_id", 64'(cdb_fu_id), 64'(0));
    check("rst_bcast", 64'(bcast_count), 64'(0));
    check("rst_conflict", 64'(conflict_count), 64'(0));
    check("rst_ptr", 64'(rr_ptr), 64'(0));
    check("rst_ack", 64'(fu_ack), 64'(0));
    model_clear();
    @(posedge clock);
    #1;
    check("rst_ack_hold", 64'(fu_ack), 64'(0));
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int g = 0; g < 2 * N && fu_done != '0; g++) tick();
    check("drain_done", 64'(fu_done), 64'(0));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    // Reset, idle
    do_reset();
    repeat (5) tick();

    // Single FU
    fu_done       = 4'b0100;
    fu_value[2]   = 32'h0000_00F0;
    fu_rob_tag[2] = 5'd7;
    tick();
    check("single_value", 64'(cdb_value), 64'h0000_00F0);
    check("single_tag", 64'(cdb_rob_tag), 64'd7);
    check("single_fu_id", 64'(cdb_fu_id), 64'd2);
    check("single_ptr", 64'(rr_ptr), 64'd3);
    tick();
    check("single_bcast", 64'(bcast_count), 64'd1);

    // All four contend from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      fu_value[i]   = 32'h1000 + 32'(i);
      fu_rob_tag[i] = TW'(10 + i);
    end
    fu_done = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tick();
      check("contend_order", 64'(cdb_fu_id), 64'(i));
    end
    check("contend_conflict", 64'(conflict_count), 64'd3);
    check("contend_bcast", 64'(bcast_count), 64'd4);
    tick();

    // Round-robin wrap: move ptr to 3, then FU1+FU3, then FU0 alone
    fu_done = 4'b0100;
    tick();
    check("wrap_ptr3", 64'(rr_ptr), 64'd3);
    fu_done = 4'b1010;
    tick();
    check("wrap_first", 64'(cdb_fu_id), 64'd3);
    tick();
    check("wrap_second", 64'(cdb_fu_id), 64'd1);
    fu_done = 4'b0001;
    tick();
    check("wrap_fu0", 64'(cdb_fu_id), 64'd0);
    tick();

    // Flush with FU0 and FU1 pending
    do_reset();
    fu_done = 4'b0011;
    flush   = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    tick();
    check("flush_first", 64'(cdb_fu_id), 64'd0);
    tick();
    check("flush_second", 64'(cdb_fu_id), 64'd1);
    tick();

    // Random traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!fu_done[i] && $urandom_range(0, 2) == 0) begin
          fu_done[i]    = 1'b1;
          fu_value[i]   = $urandom();
          fu_rob_tag[i] = TW'($urandom_range(0, 31));
        end
      end
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    // Async reset mid-operation at bcast_count = 9
    do_reset();
    for (int g = 0; g < 40 && m_bcast < 32'd9; g++) begin
      if (fu_done == '0) fu_done = 4'b1111;
      tick();
    end
    check("pre_rst_valid", 64'(cdb_valid), 64'd1);
    check("pre_rst_bcast", 64'(bcast_count), 64'd9);
    do_reset();
    // First grant right after release
    tick();
    check("post_rst_valid", 64'(cdb_valid), 64'(fu_done != 4'b0000 || bcast_count == 32'd1));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
